debug_trace_mux: RTL and testbench

Parametrised debug channel selector with an integrated trace buffer, sitting between the per-block debug buses and the M3 debug port. It registers the selected channel onto `debug_out`. A small trigger-and-capture engine records the selected channel into an on-chip circular buffer. Firmware reads the captured window back one sample per request, giving logic-analyser-style pre- and post-trigger history without external probes.

---
 rtl/debug_trace_mux.sv | 146 ++++++++++++++
 tb/tb_debug_trace_mux.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_mux.sv
// debug_trace_mux: registered debug channel selector with an optional trigger/capture trace buffer.
// Define DEBUG_TRACE_BUF_EN to build the trace buffer; otherwise only the registered mux exists.
module debug_trace_mux #(
    parameter int DEBUG_BUS_SIZE = 4,
    parameter int NUM_CHAN       = 24,
    parameter int SEL_W          = 5,
    parameter int DEPTH          = 64,
    parameter int ADDR_W         = 6
) (
    input  logic                               PCLK,
    input  logic                               PRESET,
    input  logic [NUM_CHAN*DEBUG_BUS_SIZE-1:0] debug_in,
    input  logic [SEL_W-1:0]                   chan_sel,
    output logic [DEBUG_BUS_SIZE-1:0]          debug_out,
    input  logic                               arm,
    input  logic                               abort,
    input  logic [DEBUG_BUS_SIZE-1:0]          trig_mask,
    input  logic [DEBUG_BUS_SIZE-1:0]          trig_value,
    input  logic [ADDR_W-1:0]                  post_count,
    output logic                               armed,
    output logic                               triggered,
    output logic                               done,
    input  logic                               rd_en,
    output logic [DEBUG_BUS_SIZE-1:0]          rd_data,
    output logic                               rd_valid,
    output logic                               empty
);
    logic [DEBUG_BUS_SIZE-1:0] debug_out_d, debug_out_q;

    always_comb
        debug_out_d = (int'(chan_sel) < NUM_CHAN) ?
                      debug_in[int'(chan_sel)*DEBUG_BUS_SIZE +: DEBUG_BUS_SIZE] : '0;

    always_ff @(posedge PCLK or posedge PRESET)
        if (PRESET) debug_out_q <= '0;
        else        debug_out_q <= debug_out_d;

    assign debug_out = debug_out_q;

`ifdef DEBUG_TRACE_BUF_EN
    typedef enum logic [1:0] {IDLE, PRETRIG, POST, DONE} state_t;

    state_t                    state_d, state_q;
    logic [ADDR_W-1:0]         wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q, post_cnt_d, post_cnt_q;
    logic [ADDR_W:0]           fill_d, fill_q;
    logic [DEBUG_BUS_SIZE-1:0] rd_data_d, rd_data_q;
    logic                      rd_valid_d, rd_valid_q;
    logic                      we, hit;
    logic [DEBUG_BUS_SIZE-1:0] mem [DEPTH];

    assign hit = ((debug_out_q ^ trig_value) & trig_mask) == '0;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        post_cnt_d = post_cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        we         = 1'b0;
        if (abort) begin
            state_d = IDLE;
            fill_d  = '0;
        end else if (arm) begin
            state_d  = PRETRIG;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            case (state_q)
                PRETRIG: begin
                    we = 1'b1;
                    if (hit) begin
                        state_d    = POST;
                        post_cnt_d = post_count;
                    end
                end
                POST: begin
                    if (post_cnt_q == '0) begin
                        state_d  = DONE;
                        rd_ptr_d = wr_ptr_q - fill_q[ADDR_W-1:0];
                    end else begin
                        we         = 1'b1;
                        post_cnt_d = post_cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (rd_en && fill_q != '0) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = mem[rd_ptr_q];
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        fill_d     = fill_q - 1'b1;
                    end
                end
                default: ;
            endcase
            if (we) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                fill_d   = (fill_q == (ADDR_W+1)'(DEPTH)) ? fill_q : fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET)
        if (PRESET) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            post_cnt_q <= '0;
            fill_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            post_cnt_q <= post_cnt_d;
            fill_q     <= fill_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end

    // Buffer contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge PCLK)
        if (we) mem[wr_ptr_q] <= debug_out_q;

    assign armed     = state_q == PRETRIG;
    assign triggered = state_q == POST || state_q == DONE;
    assign done      = state_q == DONE;
    assign empty     = fill_q == '0 || state_q != DONE;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
`else
    localparam int unused_depth = DEPTH;
    logic unused_in;

    assign unused_in = ^{arm, abort, trig_mask, trig_value, post_count, rd_en};
    assign armed     = 1'b0;
    assign triggered = 1'b0;
    assign done      = 1'b0;
    assign empty     = 1'b1;
    assign rd_data   = '0;
    assign rd_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_debug_trace_mux.sv
// tb_debug_trace_mux: directed checks of the channel mux and, when DEBUG_TRACE_BUF_EN is defined,
// of trace capture, windowed readout, abort and asynchronous reset.
module tb_debug_trace_mux;
    localparam int W  = 4;
    localparam int NC = 24;

    logic            PCLK = 1'b0;
    logic            PRESET = 1'b1;
    logic [NC*W-1:0] debug_in = '0;
    logic [4:0]      chan_sel = '0;
    logic            arm = 1'b0, abort = 1'b0, rd_en = 1'b0;
    logic [W-1:0]    trig_mask = '0, trig_value = '0;
    logic [5:0]      post_count = '0;
    logic [W-1:0]    debug_out, rd_data;
    logic            armed, triggered, done, rd_valid, empty;

    int           n_chk = 0, n_pass = 0;
    logic [W-1:0] dexp, prev;
    logic [W-1:0] win[$];

    debug_trace_mux dut (
        .PCLK(PCLK), .PRESET(PRESET), .debug_in(debug_in), .chan_sel(chan_sel),
        .debug_out(debug_out), .arm(arm), .abort(abort), .trig_mask(trig_mask),
        .trig_value(trig_value), .post_count(post_count), .armed(armed),
        .triggered(triggered), .done(done), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic read_win(input string tag, input int n);
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick;
            chk({tag, "_valid"}, 32'(rd_valid), 1);
            chk(tag, 32'(rd_data), 32'(win[win.size()-n+i]));
        end
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (2) tick;
        chk("rst_dout", 32'(debug_out), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_status", 32'({armed, triggered, done}), 0);
        chk("rst_empty", 32'(empty), 1);
        PRESET = 1'b0;

        debug_in[12 +: 4] = 4'hA;
        chan_sel = 5'd3;
        chk("mux_latency", 32'(debug_out), 0);
        tick;
        chk("mux_ch3", 32'(debug_out), 32'hA);
        debug_in[0 +: 4] = 4'h5;
        chan_sel = 5'd0;
        tick;
        chk("mux_ch0", 32'(debug_out), 32'h5);
        debug_in[92 +: 4] = 4'hC;
        chan_sel = 5'd23;
        tick;
        chk("mux_ch23", 32'(debug_out), 32'hC);
        chan_sel = 5'd30;
        tick;
        chk("mux_sel30", 32'(debug_out), 0);
        chan_sel = 5'd23;
        debug_in[92 +: 4] = 4'h7;
        tick;
        chk("mux_ch23_new", 32'(debug_out), 32'h7);
        chan_sel = 5'd24;
        tick;
        chk("mux_sel24", 32'(debug_out), 0);

`ifdef DEBUG_TRACE_BUF_EN
        // Full window: 60 non-matching samples from ch4, then a counter on ch3 hitting 5.
        trig_mask = 4'hF;
        trig_value = 4'h5;
        post_count = 6'd3;
        chan_sel = 5'd4;
        debug_in[16 +: 4] = 4'h8;
        tick;
        dexp = 4'h8;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        chk("arm_armed", 32'(armed), 1);
        chk("arm_empty", 32'(empty), 1);
        win.delete();
        for (int k = 1; k <= 59; k++) begin
            debug_in[16 +: 4] = 4'(8 + k % 8);
            prev = dexp;
            dexp = debug_in[16 +: 4];
            tick;
            win.push_back(prev);
        end
        chan_sel = 5'd3;
        begin
            int post = -1;
            for (int c = 0; c < 16 && post != 0; c++) begin
                debug_in[12 +: 4] = 4'(c);
                prev = dexp;
                dexp = 4'(c);
                tick;
                win.push_back(prev);
                if (post > 0) post--;
                else if (prev == 4'h5) post = 3;
            end
        end
        chk("full_trig", 32'(triggered), 1);
        chk("full_done_early", 32'(done), 0);
        tick;
        chk("full_done", 32'(done), 1);
        chk("full_not_empty", 32'(empty), 0);
        chk("full_tail", 32'({win[win.size()-4], win[win.size()-3], win[win.size()-2], win[win.size()-1]}), 32'h5678);
        read_win("full_win", 64);
        chk("full_empty_after", 32'(empty), 1);

        // Trigger on the third sample, no post samples.
        trig_value = 4'h3;
        post_count = 6'd0;
        debug_in[12 +: 4] = 4'h1;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        for (int v = 2; v <= 4; v++) begin
            debug_in[12 +: 4] = 4'(v);
            tick;
        end
        chk("t3_trig", 32'({triggered, done}), 32'b10);
        tick;
        chk("t3_done", 32'(done), 1);
        win.delete();
        win.push_back(4'h1);
        win.push_back(4'h2);
        win.push_back(4'h3);
        read_win("t3_win", 3);
        rd_en = 1'b1;
        tick;
        chk("t3_extra_valid", 32'(rd_valid), 0);
        tick;
        chk("t3_extra_valid2", 32'(rd_valid), 0);
        chk("t3_empty", 32'(empty), 1);
        rd_en = 1'b0;

        // mask 0 triggers at once; 1 + 63 samples fill the buffer and the read wraps.
        trig_mask = 4'h0;
        post_count = 6'd63;
        debug_in[12 +: 4] = 4'h0;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        win.delete();
        for (int k = 1; k <= 64; k++) begin
            debug_in[12 +: 4] = 4'(k * 5 + k / 16);
            tick;
            win.push_back(4'((k - 1) * 5 + (k - 1) / 16));
        end
        chk("wrap_done_early", 32'({triggered, done}), 32'b10);
        tick;
        chk("wrap_done", 32'(done), 1);
        read_win("wrap_win", 64);
        chk("wrap_empty", 32'(empty), 1);

        // arm and abort together while in POST: abort wins.
        post_count = 6'd10;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        repeat (2) tick;
        chk("ab_post", 32'({armed, triggered, done}), 32'b010);
        arm = 1'b1;
        abort = 1'b1;
        tick;
        arm = 1'b0;
        abort = 1'b0;
        chk("ab_status", 32'({armed, triggered, done}), 0);
        chk("ab_empty", 32'(empty), 1);
        tick;
        chk("ab_idle", 32'({armed, triggered, done}), 0);

        // Asynchronous reset in the middle of POST.
        arm = 1'b1;
        tick;
        arm = 1'b0;
        repeat (2) tick;
        chk("rst2_post", 32'(triggered), 1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("rst2_dout", 32'(debug_out), 0);
        chk("rst2_rd_data", 32'(rd_data), 0);
        chk("rst2_rd_valid", 32'(rd_valid), 0);
        chk("rst2_status", 32'({armed, triggered, done}), 0);
        chk("rst2_empty", 32'(empty), 1);
        tick;
        PRESET = 1'b0;
        tick;
        chk("rst2_mux", 32'(debug_out), 32'(4'(64 * 5 + 4)));
`else
        arm = 1'b1;
        tick;
        arm = 1'b0;
        chk("nobuf_armed", 32'(armed), 0);
        chk("nobuf_empty", 32'(empty), 1);
        rd_en = 1'b1;
        tick;
        chk("nobuf_rd_valid", 32'(rd_valid), 0);
        chk("nobuf_rd_data", 32'(rd_data), 0);
        chk("nobuf_done", 32'({triggered, done}), 0);
        tick;
        chk("nobuf_empty2", 32'(empty), 1);
        rd_en = 1'b0;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
